// File: rtl/mem_bus_master_if.sv
// Host request/response and C2 command/address signals of mem_bus_master.
// The bidirectional C2 data bus is a plain inout on the block, not part of this bundle.
interface mem_bus_master_if #(
  parameter int LA = 15,
  parameter int LW = 128
);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [LA-1:0] req_addr;
  logic [LW-1:0] req_wdata;
  logic          resp_valid;
  logic [LW-1:0] resp_rdata;
  logic [LA-1:0] mem_address;
  logic [1:0]    mem_command;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, mem_address, mem_command
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, mem_address, mem_command
  );
endinterface

// File: rtl/mem_bus_master.sv
// C2 bus initiator: turns whole-line read/write requests into 8 beats of 16 bits.
//
// state | meaning
// IDLE  | waiting for a request, bus released, command NOP
// READ  | cycles 0..8: READ command for 0..7, beats captured at end of 1..8
// WRITE | cycles 0..8: WRITE command in 0, beats driven in 1..8
// DONE  | cycle 9: one-cycle completion pulse, a new request may be accepted
module mem_bus_master #(
  parameter int MEM_ADDR_SIZE     = 19,
  parameter int BUS_SIZE          = 16,
  parameter int CACHE_OFFSET_SIZE = 4,
  parameter int CACHE_LINE_SIZE   = 16
) (
  input  logic                clk,
  input  logic                reset,
  mem_bus_master_if.master    bus,
  inout  wire  [BUS_SIZE-1:0] mem_data
);
  localparam int LA    = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
  localparam int LW    = CACHE_LINE_SIZE * 8;
  localparam int BEATS = LW / BUS_SIZE;
  localparam logic [3:0] LAST_CMD_CYC = 4'(BEATS - 1);
  localparam logic [3:0] LAST_CYC     = 4'(BEATS);

  localparam logic [1:0] CMD_NOP   = 2'd0;
  localparam logic [1:0] CMD_READ  = 2'd2;
  localparam logic [1:0] CMD_WRITE = 2'd3;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t              state;
  logic [3:0]          cyc;
  logic [1:0]          cmd_q;
  logic [LA-1:0]       addr_q;
  logic [LW-1:0]       wline;
  logic [LW-1:0]       rbuf;
  logic [LW-1:0]       rdata_q;
  logic                ready_q;
  logic                resp_valid_q;
  logic                data_oe;
  logic [BUS_SIZE-1:0] data_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cyc          <= '0;
      cmd_q        <= CMD_NOP;
      addr_q       <= '0;
      wline        <= '0;
      rbuf         <= '0;
      rdata_q      <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      data_oe      <= 1'b0;
      data_out     <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.req_valid && ready_q) begin
            state   <= bus.req_write ? WRITE : READ;
            cmd_q   <= bus.req_write ? CMD_WRITE : CMD_READ;
            cyc     <= '0;
            addr_q  <= bus.req_addr;
            wline   <= bus.req_wdata;
            ready_q <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        READ: begin
          cyc   <= cyc + 4'd1;
          cmd_q <= (cyc < LAST_CMD_CYC) ? CMD_READ : CMD_NOP;
          // Beat k is on the bus in cycle k+1; shift it in from the top.
          if (cyc != 4'd0) rbuf <= {mem_data, rbuf[LW-1:BUS_SIZE]};
          if (cyc == LAST_CYC) begin
            rdata_q      <= {mem_data, rbuf[LW-1:BUS_SIZE]};
            state        <= DONE;
            resp_valid_q <= 1'b1;
            ready_q      <= 1'b1;
          end
        end
        WRITE: begin
          cyc   <= cyc + 4'd1;
          cmd_q <= CMD_NOP;
          if (cyc < LAST_CYC) begin
            data_oe  <= 1'b1;
            data_out <= wline[int'(cyc[2:0]) * BUS_SIZE +: BUS_SIZE];
          end else begin
            data_oe      <= 1'b0;
            state        <= DONE;
            resp_valid_q <= 1'b1;
            ready_q      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_data        = data_oe ? data_out : {BUS_SIZE{1'bz}};
  assign bus.req_ready   = ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = rdata_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_command = cmd_q;
endmodule

// File: tb/tb_mem_bus_master.sv
// Scoreboard bench for mem_bus_master with a behavioural C2 memory on a pulled-up data bus.
module tb_mem_bus_master;
  localparam int LA = 15;
  localparam int LW = 128;
  localparam logic [1:0] NOP = 2'd0;
  localparam logic [1:0] RD  = 2'd2;
  localparam logic [1:0] WR  = 2'd3;
  localparam logic [15:0] FLOAT = 16'hFFFF;
  localparam logic [127:0] LINE5  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] WLINE  = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] W3     = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;
  localparam logic [127:0] WABORT = 128'h11112222333344445555666677778888;

  logic clk = 1'b0;
  logic reset = 1'b0;
  wire  [15:0] mem_data;
  logic        mem_oe = 1'b0;
  logic [15:0] mem_dout = '0;

  mem_bus_master_if #(.LA(LA), .LW(LW)) bus();
  mem_bus_master dut (.clk(clk), .reset(reset), .bus(bus), .mem_data(mem_data));

  assign mem_data = mem_oe ? mem_dout : 16'hzzzz;
  pullup (mem_data);

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  logic [1:0]    cmd_log  [int];
  logic [15:0]   data_log [int];
  logic [LA-1:0] addr_log [int];
  always @(negedge clk) begin
    cmd_log[cyc_n]  = bus.mem_command;
    data_log[cyc_n] = mem_data;
    addr_log[cyc_n] = bus.mem_address;
  end

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  typedef struct {
    bit           rd;
    logic [127:0] line;
    int           cyc;
  } exp_t;
  exp_t exp_q[$];
  logic [127:0] last_rd = '0;

  always @(negedge clk) begin
    exp_t e;
    if (reset && bus.resp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got resp_valid in cycle %0d expected none", cyc_n);
      end else begin
        e = exp_q.pop_front();
        check("resp_cycle", 128'(cyc_n), 128'(e.cyc));
        if (e.rd) begin
          check("resp_rdata", bus.resp_rdata, e.line);
          last_rd = e.line;
        end else begin
          check("rdata_hold", bus.resp_rdata, last_rd);
        end
      end
    end
  end

  // C2 memory: returns beats in cycles 1..8 after a READ, samples on negedges after a WRITE.
  logic [127:0] memory [int];
  initial begin
    logic [127:0] line;
    int a;
    bit ok;
    forever begin
      @(negedge clk);
      if (reset && bus.mem_command == RD) begin
        a = int'(bus.mem_address);
        line = memory.exists(a) ? memory[a] : '0;
        for (int k = 0; k < 8; k++) begin
          @(posedge clk); #1;
          if (!reset) break;
          mem_oe = 1'b1;
          mem_dout = line[16*k +: 16];
        end
        if (reset) begin
          @(posedge clk); #1;
        end
        mem_oe = 1'b0;
      end else if (reset && bus.mem_command == WR) begin
        a = int'(bus.mem_address);
        line = '0;
        ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          if (!reset) begin
            ok = 1'b0;
            break;
          end
          line[16*k +: 16] = mem_data;
        end
        if (ok) memory[a] = line;
      end
    end
  end

  task automatic goto_cycle(input int c);
    while (cyc_n < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push_exp(input bit rd, input logic [127:0] line, input int c);
    exp_t e;
    e.rd = rd;
    e.line = line;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic issue(input bit wr, input logic [LA-1:0] addr, input logic [127:0] wd,
                       input logic [127:0] exp_line, output int c0);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(negedge clk);
    while (!bus.req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got req_ready=0 for %0d cycles expected 1", n);
    end
    c0 = cyc_n + 1;
    push_exp(!wr, exp_line, c0 + 9);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("resp_arrived", 128'(exp_q.size()), 128'(0));
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic check_trace(input bit wr, input int c0, input logic [LA-1:0] addr,
                             input logic [127:0] line);
    logic [1:0]  ec;
    logic [15:0] ed;
    for (int c = 0; c < 10; c++) begin
      if (wr) ec = (c == 0) ? WR : NOP;
      else    ec = (c <= 7) ? RD : NOP;
      ed = (c >= 1 && c <= 8) ? line[16*(c-1) +: 16] : FLOAT;
      check($sformatf("cmd_c%0d", c), 128'(cmd_log[c0+c]), 128'(ec));
      check($sformatf("data_c%0d", c), 128'(data_log[c0+c]), 128'(ed));
      if (c <= 8) check($sformatf("addr_c%0d", c), 128'(addr_log[c0+c]), 128'(addr));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int c1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    memory[5] = LINE5;

    // reset state
    @(negedge clk);
    check("rst_ready", 128'(bus.req_ready), 128'(1));
    check("rst_resp_valid", 128'(bus.resp_valid), 128'(0));
    check("rst_cmd", 128'(bus.mem_command), 128'(NOP));
    check("rst_addr", 128'(bus.mem_address), 128'(0));
    check("rst_rdata", bus.resp_rdata, 128'(0));
    check("rst_data_z", 128'(mem_data), 128'(FLOAT));
    reset = 1'b1;

    // idle: bus released, NOP
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_data_z", 128'(mem_data), 128'(FLOAT));
      check("idle_cmd", 128'(bus.mem_command), 128'(NOP));
    end

    // read line 5
    issue(1'b0, 15'd5, '0, LINE5, c0);
    wait_resp();
    check_trace(1'b0, c0, 15'd5, LINE5);

    // write line 0x7FFF
    issue(1'b1, 15'h7FFF, WLINE, '0, c0);
    wait_resp();
    check_trace(1'b1, c0, 15'h7FFF, WLINE);
    check("mem_write_line", memory.exists(32'h7FFF) ? memory[32'h7FFF] : '0, WLINE);

    // back-to-back: write 3 with req_valid held, read 3 accepted in DONE
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 15'd3;
    bus.req_wdata = W3;
    @(negedge clk);
    check("b2b_ready", 128'(bus.req_ready), 128'(1));
    c0 = cyc_n + 1;
    push_exp(1'b0, '0, c0 + 9);
    goto_cycle(c0);
    bus.req_write = 1'b0;
    bus.req_wdata = '0;
    push_exp(1'b1, W3, c0 + 19);
    goto_cycle(c0 + 10);
    bus.req_valid = 1'b0;
    wait_resp();
    check_trace(1'b1, c0, 15'd3, W3);
    check_trace(1'b0, c0 + 10, 15'd3, W3);

    // ignored req_valid pulses in cycles 2..8
    issue(1'b0, 15'd5, '0, LINE5, c0);
    goto_cycle(c0 + 2);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 15'h55;
    goto_cycle(c0 + 9);
    bus.req_valid = 1'b0;
    wait_resp();
    goto_cycle(c0 + 16);
    check_trace(1'b0, c0, 15'd5, LINE5);
    for (int c = 10; c < 16; c++)
      check($sformatf("ignore_cmd_c%0d", c), 128'(cmd_log[c0+c]), 128'(NOP));

    // reset in the middle of a write, at beat 3
    issue(1'b1, 15'h100, WABORT, '0, c0);
    goto_cycle(c0 + 4);
    @(negedge clk);
    check("abort_beat3", 128'(mem_data), 128'(WABORT[63:48]));
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("abort_data_z", 128'(mem_data), 128'(FLOAT));
    check("abort_cmd", 128'(bus.mem_command), 128'(NOP));
    check("abort_ready", 128'(bus.req_ready), 128'(1));
    check("abort_resp_valid", 128'(bus.resp_valid), 128'(0));
    check("abort_addr", 128'(bus.mem_address), 128'(0));
    check("abort_rdata", bus.resp_rdata, 128'(0));
    last_rd = '0;
    // request presented during reset is taken at the first posedge after release
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 15'd5;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    c1 = cyc_n + 1;
    push_exp(1'b1, LINE5, c1 + 9);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_resp();
    check_trace(1'b0, c1, 15'd5, LINE5);
    check("abort_mem_untouched", 128'(memory.exists(32'h100)), 128'(0));

    check("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
